// File: rtl/tl_grant_pkg.sv
// Shared constants and types for the AXI4 R/B to TileLink Grant converter.
package tl_grant_pkg;

  localparam int TL_ID_W   = 2;
  localparam int TL_BEATS  = 8;
  localparam int TL_BEAT_W = $clog2(TL_BEATS);

  localparam logic [3:0] G_PUT_ACK        = 4'd1;
  localparam logic [3:0] G_GET_DATA_BEAT  = 4'd3;
  localparam logic [3:0] G_GET_DATA_BLOCK = 4'd4;

  typedef struct packed {
    logic                 valid;
    logic                 is_write;
    logic                 is_block;
    logic [TL_BEAT_W-1:0] addr_beat;
  } trk_entry_t;

  typedef enum logic {
    S_IDLE,
    S_R_BURST
  } state_e;

endpackage

// File: rtl/grant_tracker_table.sv
// Per-ID outstanding-transaction table: written on allocate, cleared on free,
// looked up combinationally by the R and B channel IDs.
module grant_tracker_table
  import tl_grant_pkg::*;
#(
  parameter int ID_W = TL_ID_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_i,
  input  logic [ID_W-1:0]      alloc_id_i,
  input  logic                 alloc_is_write_i,
  input  logic                 alloc_is_block_i,
  input  logic [TL_BEAT_W-1:0] alloc_addr_beat_i,
  input  logic                 free_i,
  input  logic [ID_W-1:0]      free_id_i,
  input  logic [ID_W-1:0]      r_id_i,
  input  logic [ID_W-1:0]      b_id_i,
  output trk_entry_t           r_entry_o,
  output trk_entry_t           b_entry_o,
  output logic [2**ID_W-1:0]   busy_o
);

  localparam int NUM = 2**ID_W;

  trk_entry_t tbl_q [NUM];
  trk_entry_t tbl_d [NUM];

  // Free is applied after allocate so it wins on a same-ID collision.
  always_comb begin
    tbl_d = tbl_q;
    if (alloc_i) tbl_d[alloc_id_i] = '{1'b1, alloc_is_write_i, alloc_is_block_i, alloc_addr_beat_i};
    if (free_i)  tbl_d[free_id_i].valid = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) tbl_q <= '{default: '0};
    else       tbl_q <= tbl_d;
  end

  always_comb begin
    busy_o = '0;
    for (int i = 0; i < NUM; i++) busy_o[i] = tbl_q[i].valid;
  end

  assign r_entry_o = tbl_q[r_id_i];
  assign b_entry_o = tbl_q[b_id_i];

endmodule

// File: rtl/tl_grant_from_axi4.sv
// Merges AXI4 R and B responses onto a single TileLink Grant channel;
// R bursts are never interleaved and protocol violations raise a sticky error.
module tl_grant_from_axi4
  import tl_grant_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ID_W   = TL_ID_W,
  parameter int BEATS  = TL_BEATS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_alloc_valid,
  output logic                 io_alloc_ready,
  input  logic [ID_W-1:0]      io_alloc_id,
  input  logic                 io_alloc_is_write,
  input  logic                 io_alloc_is_block,
  input  logic [TL_BEAT_W-1:0] io_alloc_addr_beat,
  input  logic                 io_r_valid,
  output logic                 io_r_ready,
  input  logic [ID_W-1:0]      io_r_id,
  input  logic [DATA_W-1:0]    io_r_data,
  input  logic [1:0]           io_r_resp,
  input  logic                 io_r_last,
  input  logic                 io_b_valid,
  output logic                 io_b_ready,
  input  logic [ID_W-1:0]      io_b_id,
  input  logic [1:0]           io_b_resp,
  output logic                 io_grant_valid,
  input  logic                 io_grant_ready,
  output logic [TL_BEAT_W-1:0] io_grant_bits_addr_beat,
  output logic [ID_W-1:0]      io_grant_bits_client_xact_id,
  output logic                 io_grant_bits_manager_xact_id,
  output logic                 io_grant_bits_is_builtin_type,
  output logic [3:0]           io_grant_bits_g_type,
  output logic [DATA_W-1:0]    io_grant_bits_data,
  output logic [2**ID_W-1:0]   io_busy,
  output logic                 io_err
);

  localparam logic [TL_BEAT_W-1:0] BEAT_LAST = TL_BEAT_W'(BEATS - 1);

  state_e               state_q, state_d;
  logic [TL_BEAT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]      burst_id_q, burst_id_d;
  logic                 err_q, err_d;
  logic                 free;
  logic [ID_W-1:0]      free_id;
  trk_entry_t           r_entry, b_entry;
  logic                 r_ok, b_ok, alloc_fire;
  logic                 unused_bits;

  assign io_alloc_ready = !io_busy[io_alloc_id];
  assign alloc_fire     = io_alloc_valid && io_alloc_ready;
  assign unused_bits    = ^{io_r_resp, io_b_resp, b_entry.is_block, b_entry.addr_beat};

  grant_tracker_table #(.ID_W(ID_W)) u_table (
    .clk               (clk),
    .reset             (reset),
    .alloc_i           (alloc_fire),
    .alloc_id_i        (io_alloc_id),
    .alloc_is_write_i  (io_alloc_is_write),
    .alloc_is_block_i  (io_alloc_is_block),
    .alloc_addr_beat_i (io_alloc_addr_beat),
    .free_i            (free),
    .free_id_i         (free_id),
    .r_id_i            (io_r_id),
    .b_id_i            (io_b_id),
    .r_entry_o         (r_entry),
    .b_entry_o         (b_entry),
    .busy_o            (io_busy)
  );

  assign r_ok = r_entry.valid && !r_entry.is_write;
  assign b_ok = b_entry.valid &&  b_entry.is_write;

  assign io_grant_bits_manager_xact_id = 1'b0;
  assign io_grant_bits_is_builtin_type = 1'b1;
  assign io_err                        = err_q;

  always_comb begin
    state_d                      = state_q;
    cnt_d                        = cnt_q;
    burst_id_d                   = burst_id_q;
    err_d                        = err_q;
    free                         = 1'b0;
    free_id                      = io_r_id;
    io_r_ready                   = 1'b0;
    io_b_ready                   = 1'b0;
    io_grant_valid               = 1'b0;
    io_grant_bits_g_type         = G_PUT_ACK;
    io_grant_bits_addr_beat      = '0;
    io_grant_bits_client_xact_id = io_r_id;
    io_grant_bits_data           = '0;
    unique case (state_q)
      S_IDLE: begin
        if (io_b_valid) begin
          io_grant_bits_client_xact_id = io_b_id;
          if (!b_ok) begin
            io_b_ready = 1'b1;
            err_d      = 1'b1;
          end else begin
            io_grant_valid = 1'b1;
            io_b_ready     = io_grant_ready;
            free           = io_grant_ready;
            free_id        = io_b_id;
          end
        end else if (io_r_valid) begin
          if (!r_ok) begin
            io_r_ready = 1'b1;
            err_d      = 1'b1;
          end else begin
            io_grant_valid     = 1'b1;
            io_r_ready         = io_grant_ready;
            io_grant_bits_data = io_r_data;
            if (r_entry.is_block) begin
              io_grant_bits_g_type    = G_GET_DATA_BLOCK;
              io_grant_bits_addr_beat = cnt_q;
            end else begin
              io_grant_bits_g_type    = G_GET_DATA_BEAT;
              io_grant_bits_addr_beat = r_entry.addr_beat;
            end
            if (io_grant_ready) begin
              if (r_entry.is_block && !io_r_last) begin
                state_d    = S_R_BURST;
                cnt_d      = cnt_q + 1'b1;
                burst_id_d = io_r_id;
              end else begin
                free = 1'b1;
                // A block read ending on its first beat is an early last.
                if (r_entry.is_block) err_d = 1'b1;
              end
            end
          end
        end
      end
      S_R_BURST: begin
        if (io_r_valid && (io_r_id == burst_id_q)) begin
          io_grant_valid          = 1'b1;
          io_r_ready              = io_grant_ready;
          io_grant_bits_data      = io_r_data;
          io_grant_bits_g_type    = G_GET_DATA_BLOCK;
          io_grant_bits_addr_beat = cnt_q;
          if (io_grant_ready) begin
            if ((cnt_q == BEAT_LAST) || io_r_last) begin
              free    = 1'b1;
              free_id = burst_id_q;
              cnt_d   = '0;
              state_d = S_IDLE;
              if ((cnt_q == BEAT_LAST) != io_r_last) err_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (reset) begin
      io_grant_valid = 1'b0;
      io_r_ready     = 1'b0;
      io_b_ready     = 1'b0;
      free           = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      burst_id_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      burst_id_q <= burst_id_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: doc/tl_grant_from_axi4.md
Name: tl_grant_from_axi4

Overview:
- Converts AXI4 read-data (R) and write-response (B) channels into TileLink uncached Grant beats.
- Output feeds the single-entry grant queue in front of the client port.
- Holds a per-transaction tracker table, written when an Acquire is issued to AXI. The table supplies the Grant type and the beat numbering.
- Arbitrates R and B onto the one Grant channel. An R burst is never interleaved.

Parameters:
- DATA_W, 64, data beat width.
- ID_W, 2, AXI ID width, equal to client_xact_id width; tracker depth is 2^ID_W.
- BEATS, 8, beats per cache block; addr_beat width = log2(BEATS) = 3.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- io_alloc_valid  in  1  record a new outstanding transaction.
- io_alloc_ready  out  1  tracker entry io_alloc_id is free.
- io_alloc_id  in  ID_W  client_xact_id, equal to the AXI ID used.
- io_alloc_is_write  in  1  1 = put, expects B; 0 = get, expects R.
- io_alloc_is_block  in  1  1 = BEATS-beat read, 0 = single beat.
- io_alloc_addr_beat  in  3  beat index for a single-beat get.
- io_r_valid / io_r_ready  in/out  1  AXI R handshake.
- io_r_id  in  ID_W  AXI R ID.
- io_r_data  in  DATA_W  AXI R data.
- io_r_resp  in  2  AXI R response; ignored.
- io_r_last  in  1  AXI R last.
- io_b_valid / io_b_ready  in/out  1  AXI B handshake.
- io_b_id  in  ID_W  AXI B ID.
- io_b_resp  in  2  AXI B response; ignored.
- io_grant_valid / io_grant_ready  out/in  1  Grant handshake.
- io_grant_bits_addr_beat  out  3  Grant beat index.
- io_grant_bits_client_xact_id  out  ID_W  Grant client transaction ID.
- io_grant_bits_manager_xact_id  out  1  Grant manager transaction ID.
- io_grant_bits_is_builtin_type  out  1  Grant built-in type flag.
- io_grant_bits_g_type  out  4  Grant type.
- io_grant_bits_data  out  DATA_W  Grant data.
- io_busy  out  2^ID_W  tracker valid bitmask.
- io_err  out  1  sticky protocol-error flag.

Behaviour:
- One clock; reset is synchronous and active-high. Clock and reset ports are named clk and reset.
- Reset values:
  - tracker all invalid, io_busy=0, io_err=0.
  - state=IDLE, beat counter=0.
  - io_grant_valid=0, io_r_ready=0, io_b_ready=0.
- Reset mid-burst abandons the burst and clears all entries. No Grant is emitted in the reset cycle.
- Tracker entry fields: {valid, is_write, is_block, addr_beat}.
  - Allocate when io_alloc_valid && io_alloc_ready.
  - io_alloc_ready = !valid[io_alloc_id].
- Datapath is combinational, zero latency:
  - grant_valid follows the selected source's valid.
  - The selected source's ready = io_grant_ready; the unselected ready = 0.
- Constant fields: manager_xact_id=0, is_builtin_type=1.
- g_type:
  - B gives PUT_ACK (4'd1), data=0, addr_beat=0.
  - R with is_block=0 gives GET_DATA_BEAT (4'd3), addr_beat = entry.addr_beat.
  - R with is_block=1 gives GET_DATA_BLOCK (4'd4), addr_beat = beat counter.
- FSM:
  - IDLE: B has priority over R.
    - B handshake: Grant sent, entry[b_id] freed, stay in IDLE.
    - R handshake with is_block=1 and !r_last: counter becomes 1, go to R_BURST and latch r_id.
    - R handshake with single beat (or r_last): entry freed, stay in IDLE.
  - R_BURST: only R with the latched id is selected; B is stalled (b_ready=0).
    - Each handshake increments the 3-bit counter.
    - When the counter equals BEATS-1, r_last is required. On that beat: free the entry, counter becomes 0, go to IDLE.
- Simultaneous allocate and free of the same id in one cycle: the free wins, then the allocate is refused (alloc_ready reflects the pre-cycle state, so this cannot occur legally).
- Errors set io_err (sticky until reset):
  - R/B beat whose id entry is invalid, or whose kind mismatches is_write: the beat is consumed (ready=1) and dropped, no Grant is emitted.
  - r_last asserted early, or absent at beat BEATS-1: the burst is terminated at that beat (entry freed, IDLE).

Decomposition:
- Shared package tl_grant_pkg:
  - constants G_PUT_ACK=1, G_GET_DATA_BEAT=3, G_GET_DATA_BLOCK=4.
  - ID_W, BEATS, addr_beat width.
- Sub-module grant_tracker_table: 2^ID_W-entry register file with alloc and free ports, and read lookup by r_id/b_id. Arbitration and FSM stay in the top level.

Test Plan:
- Alloc id1 put; B id1 -> one Grant {g_type=1, ctxid=1, addr_beat=0, data=0}; busy[1] clears next cycle.
- Alloc id2 block get; 8 R beats data 0x10..0x17 with last on beat 7 -> Grants addr_beat 0..7 with the matching data, g_type=4; busy[2]=0 after the last beat.
- Alloc id0 single get with addr_beat=5; one R beat, last=1 -> Grant {g_type=3, addr_beat=5}.
- Mid block burst with B valid for another allocated id -> b_ready=0 until the burst's beat 7 completes; B Grant follows next. Repeat with grant_ready toggled 0/1: no beat lost or duplicated.
- B with an unallocated id -> b_ready=1, no Grant, io_err=1 and held until reset; reset -> io_err=0, busy=0.
- Block burst with r_last on beat 3 -> io_err=1, burst terminated after beat 3, FSM back in IDLE and accepting a new B.
